shift_reg_burst: RTL and testbench
==================================

Name: shift_reg_burst

Overview:
- Parametrised successor to the team's 8-bit serial/parallel shift register.
- Adds a configurable width, a direction select, and three modes: shift, rotate and bounce (Cylon sweep).
- Adds a counted burst-shift engine with a START/BUSY/DONE handshake, so the 8051 firmware can request N shifts with one write.
- Sits between the 8051 port-write logic and the LED driver.

Parameters:
- WIDTH, 8: register width in bits; minimum 2.
- CNT_W, 4: width of the COUNT input; bursts of 0 to 2^CNT_W-1 shifts.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- DI  input  1  serial data in; fills the vacated bit in mode 00.
- DO  output  1  registered copy of the last bit shifted out.
- PLD  input  WIDTH  parallel load data.
- PLDEN  input  1  parallel load enable.
- POUT  output  WIDTH  register contents.
- EN  input  1  single-step shift enable.
- DIR  input  1  0 = shift toward MSB (left), 1 = toward LSB (right).
- MODE  input  2  00 shift, 01 rotate, 10 bounce, 11 reserved.
- START  input  1  one-cycle request to begin a burst.
- COUNT  input  CNT_W  number of shifts in the burst; sampled with START.
- BUSY  output  1  burst in progress.
- DONE  output  1  one-cycle pulse when a burst completes.
- DIR_Q  output  1  effective direction register.

Behaviour:
- Reset (async, RST_N=0): POUT=0, DO=0, BUSY=0, DONE=0, DIR_Q=0, FSM=IDLE, remaining-count=0. Reset mid-burst aborts the burst immediately; no DONE pulse is produced.
- FSM states: IDLE and RUN.
- IDLE, priority PLDEN > START > EN:
  - PLDEN: POUT<=PLD, DIR_Q<=DIR. DO holds. No shift.
  - START, COUNT>0: remaining<=COUNT, BUSY<=1, go to RUN. No shift on this edge. EN in the same cycle is ignored.
  - START, COUNT=0: DONE<=1 for one cycle, stay IDLE. POUT unchanged.
  - EN: one shift step, as defined below.
- RUN:
  - One shift step per clock; remaining decrements each step.
  - The edge performing the final step sets BUSY<=0 and DONE<=1, then returns to IDLE.
  - Timing: START sampled at edge k → shifts at edges k+1 .. k+N → BUSY high for exactly N cycles. DONE is high for the cycle after edge k+N.
  - PLDEN, START and EN are ignored while BUSY=1.
- DONE: defaults low every cycle; never high for two consecutive cycles.
- Shift step, direction:
  - Modes 00/01: DIR_Q<=DIR, and the step uses DIR.
  - Mode 10: the step uses DIR_Q.
- Left step: POUT<=POUT<<1, fill at bit 0; DO<=old POUT[WIDTH-1].
- Right step: POUT<=POUT>>1, fill at bit WIDTH-1; DO<=old POUT[0].
- Fill per mode:
  - Mode 00: fill=DI.
  - Mode 01: fill=the outgoing bit, i.e. rotate.
  - Mode 10: fill=0.
- Bounce rule (mode 10):
  - If DIR_Q=0 and old POUT[WIDTH-1]=1: DIR_Q<=1 and a right step is performed in the same cycle.
  - If DIR_Q=1 and old POUT[0]=1: DIR_Q<=0 and a left step is performed.
  - If both end bits are set, direction flips once per step per this rule.
- Mode 11: the step is a no-op. POUT and DO hold, remaining still decrements, and burst timing is unchanged.
- MODE and DIR are sampled every step, not latched at START; changing them mid-burst takes effect on the next step.
- Widths: remaining is CNT_W bits. All arithmetic is unsigned and decrement-only, so no wrap occurs.

Test Plan:
- Reset / load: assert RST_N=0 mid-operation → POUT=0, DO=0, BUSY=0, DONE=0, DIR_Q=0 immediately. Release, PLD=8'hA5, PLDEN=1 → POUT=8'hA5.
- Shift: POUT=8'hA5, MODE=00, DIR=0, DI=1, EN for one cycle → POUT=8'h4B, DO=1. Then DIR=1, DI=0, EN → POUT=8'h25, DO=1.
- Rotate: load 8'h81, MODE=01, DIR=1, EN → POUT=8'hC0, DO=1. EN ×7 more → POUT=8'h81 again.
- Bounce burst:
  - Load 8'h40 with DIR=0, MODE=10, START with COUNT=3.
  - Expected POUT sequence: 8'h80, 8'h40, 8'h20; DIR_Q=1 after the second shift.
  - BUSY high for exactly 3 cycles; DONE high for 1 cycle; PLDEN and START pulsed mid-burst have no effect.
- Zero count: START with COUNT=0 → DONE high one cycle after, BUSY stays 0, POUT unchanged. START and EN together with COUNT=2 → no shift on the START edge, then 2 shifts.
- Abort: START with COUNT=15, assert RST_N=0 after 5 shifts → all outputs reset immediately, no DONE. After release, FSM is IDLE and accepts a new START.

Source files
------------

// File: rtl/shift_reg_burst_if.sv
// Bus between the 8051 port-write logic and the burst shift register.
// Clock and reset are plain module ports and are not part of this interface.
interface shift_reg_burst_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             DI;
    logic             DO;
    logic [WIDTH-1:0] PLD;
    logic             PLDEN;
    logic [WIDTH-1:0] POUT;
    logic             EN;
    logic             DIR;
    logic [1:0]       MODE;
    logic             START;
    logic [CNT_W-1:0] COUNT;
    logic             BUSY;
    logic             DONE;
    logic             DIR_Q;

    modport master (
        output DI, PLD, PLDEN, EN, DIR, MODE, START, COUNT,
        input  DO, POUT, BUSY, DONE, DIR_Q
    );

    modport slave (
        input  DI, PLD, PLDEN, EN, DIR, MODE, START, COUNT,
        output DO, POUT, BUSY, DONE, DIR_Q
    );
endinterface

// File: rtl/shift_reg_burst.sv
// Parametrised shift/rotate/bounce register with a counted burst engine.
// START loads a shift count; one step per clock follows, then DONE pulses.
module shift_reg_burst #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    shift_reg_burst_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             do_q, do_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dir_q_q, dir_q_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] step_pout;
    logic             step_do;
    logic             step_dir_q;
    logic             go_right;
    logic             out_bit;
    logic             fill;

    // One shift step as a function of current state and MODE/DIR/DI.
    always_comb begin
        step_pout  = pout_q;
        step_do    = do_q;
        step_dir_q = dir_q_q;
        go_right   = bus.DIR;
        fill       = 1'b0;
        unique case (bus.MODE)
            2'b00, 2'b01: begin
                go_right   = bus.DIR;
                step_dir_q = bus.DIR;
            end
            2'b10: begin
                // Bounce off whichever end the sweep is heading toward.
                if (!dir_q_q && pout_q[WIDTH-1])
                    go_right = 1'b1;
                else if (dir_q_q && pout_q[0])
                    go_right = 1'b0;
                else
                    go_right = dir_q_q;
                step_dir_q = go_right;
            end
            default: ;
        endcase
        out_bit = go_right ? pout_q[0] : pout_q[WIDTH-1];
        unique case (bus.MODE)
            2'b00:   fill = bus.DI;
            2'b01:   fill = out_bit;
            default: fill = 1'b0;
        endcase
        if (bus.MODE != 2'b11) begin
            step_do   = out_bit;
            step_pout = go_right ? {fill, pout_q[WIDTH-1:1]}
                                 : {pout_q[WIDTH-2:0], fill};
        end
    end

    always_comb begin
        state_d = state_q;
        pout_d  = pout_q;
        do_d    = do_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dir_q_d = dir_q_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (bus.PLDEN) begin
                    pout_d  = bus.PLD;
                    dir_q_d = bus.DIR;
                end else if (bus.START) begin
                    if (bus.COUNT != '0) begin
                        rem_d   = bus.COUNT;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (bus.EN) begin
                    pout_d  = step_pout;
                    do_d    = step_do;
                    dir_q_d = step_dir_q;
                end
            end
            RUN: begin
                pout_d  = step_pout;
                do_d    = step_do;
                dir_q_d = step_dir_q;
                rem_d   = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            pout_q  <= '0;
            do_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q_q <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            pout_q  <= pout_d;
            do_q    <= do_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dir_q_q <= dir_q_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.POUT  = pout_q;
    assign bus.DO    = do_q;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
    assign bus.DIR_Q = dir_q_q;
endmodule

// File: tb/tb_shift_reg_burst.sv
// Directed bench for shift_reg_burst: expectations are queued with each stimulus
// step and popped/compared once the DUT has produced the corresponding output.
module tb_shift_reg_burst;
    logic CLK;
    logic RST_N;

    shift_reg_burst_if #(.WIDTH(8), .CNT_W(4)) bus ();

    shift_reg_burst #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    typedef struct {
        string      tag;
        logic [7:0] pout;
        logic       dout;
        logic       busy;
        logic       done;
        logic       dirq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit expired, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input string tag, input logic [7:0] pout, input logic dout,
                        input logic busy, input logic done, input logic dirq);
        exp_t e;
        e.tag  = tag;
        e.pout = pout;
        e.dout = dout;
        e.busy = busy;
        e.done = done;
        e.dirq = dirq;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input string field,
                       input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", tag, field, got, exp);
            $error("%s.%s got %h expected %h", tag, field, got, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        $display("txn %-12s pout=%h do=%b busy=%b done=%b dir_q=%b", e.tag,
                 bus.POUT, bus.DO, bus.BUSY, bus.DONE, bus.DIR_Q);
        cmp(e.tag, "pout",  bus.POUT,        e.pout);
        cmp(e.tag, "do",    {7'd0, bus.DO},    {7'd0, e.dout});
        cmp(e.tag, "busy",  {7'd0, bus.BUSY},  {7'd0, e.busy});
        cmp(e.tag, "done",  {7'd0, bus.DONE},  {7'd0, e.done});
        cmp(e.tag, "dir_q", {7'd0, bus.DIR_Q}, {7'd0, e.dirq});
    endtask

    initial begin
        logic [7:0] r;
        logic       o;

        RST_N     = 1'b0;
        bus.DI    = 1'b0;
        bus.PLD   = '0;
        bus.PLDEN = 1'b0;
        bus.EN    = 1'b0;
        bus.DIR   = 1'b0;
        bus.MODE  = 2'b00;
        bus.START = 1'b0;
        bus.COUNT = '0;
        repeat (2) cyc();
        push("reset", 8'h00, 0, 0, 0, 0);
        check_pop();
        RST_N = 1'b1;

        // Load with DIR=1 so the asynchronous reset has something to clear.
        bus.PLD = 8'hFF; bus.PLDEN = 1'b1; bus.DIR = 1'b1;
        push("load_ff", 8'hFF, 0, 0, 0, 1);
        cyc(); check_pop();
        bus.PLDEN = 1'b0;
        #2; RST_N = 1'b0;
        push("async_rst", 8'h00, 0, 0, 0, 0);
        #1; check_pop();
        @(posedge CLK); #1; RST_N = 1'b1;

        bus.PLD = 8'hA5; bus.PLDEN = 1'b1; bus.DIR = 1'b0;
        push("load_a5", 8'hA5, 0, 0, 0, 0);
        cyc(); check_pop();
        bus.PLDEN = 1'b0;

        bus.MODE = 2'b00; bus.DIR = 1'b0; bus.DI = 1'b1; bus.EN = 1'b1;
        push("shl_di1", 8'h4B, 1, 0, 0, 0);
        cyc(); check_pop();
        bus.DIR = 1'b1; bus.DI = 1'b0;
        push("shr_di0", 8'h25, 1, 0, 0, 1);
        cyc(); check_pop();
        bus.EN = 1'b0;

        bus.PLD = 8'h81; bus.PLDEN = 1'b1; bus.DIR = 1'b1;
        push("load_81", 8'h81, 1, 0, 0, 1);
        cyc(); check_pop();
        bus.PLDEN = 1'b0;

        bus.MODE = 2'b01; bus.EN = 1'b1;
        push("rot_r0", 8'hC0, 1, 0, 0, 1);
        cyc(); check_pop();
        r = 8'hC0;
        for (int i = 1; i <= 7; i++) begin
            o = r[0];
            r = {r[0], r[7:1]};
            push($sformatf("rot_r%0d", i), r, o, 0, 0, 1);
            cyc(); check_pop();
        end
        bus.EN = 1'b0;

        // Bounce burst, with PLDEN and START poked mid-burst.
        bus.PLD = 8'h40; bus.PLDEN = 1'b1; bus.DIR = 1'b0;
        push("load_40", 8'h40, 1, 0, 0, 0);
        cyc(); check_pop();
        bus.PLDEN = 1'b0;
        bus.MODE = 2'b10; bus.START = 1'b1; bus.COUNT = 4'd3;
        push("bnc_start", 8'h40, 1, 1, 0, 0);
        cyc(); check_pop();
        bus.START = 1'b0;
        push("bnc_s1", 8'h80, 0, 1, 0, 0);
        cyc(); check_pop();
        bus.PLD = 8'hFF; bus.PLDEN = 1'b1; bus.START = 1'b1; bus.COUNT = 4'd5;
        push("bnc_s2", 8'h40, 0, 1, 0, 1);
        cyc(); check_pop();
        bus.PLDEN = 1'b0; bus.START = 1'b0;
        push("bnc_s3", 8'h20, 0, 0, 1, 1);
        cyc(); check_pop();
        push("bnc_after", 8'h20, 0, 0, 0, 1);
        cyc(); check_pop();

        bus.MODE = 2'b00; bus.START = 1'b1; bus.COUNT = 4'd0;
        push("zero_cnt", 8'h20, 0, 0, 1, 1);
        cyc(); check_pop();
        bus.START = 1'b0;
        push("zero_after", 8'h20, 0, 0, 0, 1);
        cyc(); check_pop();

        // START and EN together: START wins, no shift on that edge.
        bus.START = 1'b1; bus.EN = 1'b1; bus.COUNT = 4'd2; bus.DIR = 1'b0; bus.DI = 1'b1;
        push("st_en", 8'h20, 0, 1, 0, 1);
        cyc(); check_pop();
        bus.START = 1'b0; bus.EN = 1'b0;
        push("st_en_s1", 8'h41, 0, 1, 0, 0);
        cyc(); check_pop();
        push("st_en_s2", 8'h83, 0, 0, 1, 0);
        cyc(); check_pop();
        push("st_en_aft", 8'h83, 0, 0, 0, 0);
        cyc(); check_pop();

        // Long burst aborted by reset after five shifts.
        bus.DI = 1'b0; bus.START = 1'b1; bus.COUNT = 4'd15;
        push("abort_go", 8'h83, 0, 1, 0, 0);
        cyc(); check_pop();
        bus.START = 1'b0;
        push("abort_s1", 8'h06, 1, 1, 0, 0);
        cyc(); check_pop();
        push("abort_s2", 8'h0C, 0, 1, 0, 0);
        cyc(); check_pop();
        push("abort_s3", 8'h18, 0, 1, 0, 0);
        cyc(); check_pop();
        push("abort_s4", 8'h30, 0, 1, 0, 0);
        cyc(); check_pop();
        push("abort_s5", 8'h60, 0, 1, 0, 0);
        cyc(); check_pop();
        #2; RST_N = 1'b0;
        push("abort_rst", 8'h00, 0, 0, 0, 0);
        #1; check_pop();
        push("abort_hold", 8'h00, 0, 0, 0, 0);
        cyc(); check_pop();
        RST_N = 1'b1;
        push("abort_idle", 8'h00, 0, 0, 0, 0);
        cyc(); check_pop();

        bus.DI = 1'b1; bus.START = 1'b1; bus.COUNT = 4'd1;
        push("restart", 8'h00, 0, 1, 0, 0);
        cyc(); check_pop();
        bus.START = 1'b0;
        push("restart_s1", 8'h01, 0, 0, 1, 0);
        cyc(); check_pop();
        push("restart_aft", 8'h01, 0, 0, 0, 0);
        cyc(); check_pop();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
